// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding word request, a one-deep response buffer,
// stall/redirect handling and a sticky halt on misaligned redirect targets.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirectPC,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic        imemRvalid,
    input  logic [31:0] imemRdata,
    output logic [31:0] PC,
    output logic [31:0] inst,
    output logic        instWrite,
    output logic        misaligned,
    output logic [2:0]  dbg_state
);

    // Handshake: a request transfers on a cycle with imemReq & imemReady; the memory
    // returns exactly one imemRvalid beat per transferred request, in order.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_HALT = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        inst_write_q, inst_write_d;
    logic        misaligned_q, misaligned_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    logic        discard_q, discard_d;
    logic        imem_req_q, imem_req_d;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        req_pc_d     = req_pc_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_write_d = 1'b0;
        misaligned_d = misaligned_q;
        buf_valid_d  = buf_valid_q;
        buf_pc_d     = buf_pc_q;
        buf_inst_d   = buf_inst_q;
        discard_d    = discard_q;

        if (redirect && state_q != S_HALT) begin
            buf_valid_d = 1'b0;
            inst_d      = NOP_INST;
            if (redirectPC[1:0] != 2'b00) begin
                misaligned_d = 1'b1;
                discard_d    = 1'b0;
                state_d      = S_HALT;
            end else begin
                fetch_pc_d = redirectPC;
                case (state_q)
                    // An old-address request accepted this cycle must have its response dropped.
                    S_REQ: begin
                        if (imemReady) begin
                            discard_d = 1'b1;
                            state_d   = S_WAIT;
                        end else begin
                            state_d = S_REQ;
                        end
                    end
                    S_WAIT: begin
                        if (imemRvalid) begin
                            discard_d = 1'b0;
                            state_d   = S_REQ;
                        end else begin
                            discard_d = 1'b1;
                        end
                    end
                    default: state_d = S_REQ;
                endcase
            end
        end else begin
            case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ: begin
                    if (imemReady) begin
                        req_pc_d   = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imemRvalid) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            state_d   = S_REQ;
                        end else if (!stall && !buf_valid_q) begin
                            pc_d         = req_pc_q;
                            inst_d       = imemRdata;
                            inst_write_d = 1'b1;
                            state_d      = S_REQ;
                        end else begin
                            buf_valid_d = 1'b1;
                            buf_pc_d    = req_pc_q;
                            buf_inst_d  = imemRdata;
                            state_d     = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        pc_d         = buf_pc_q;
                        inst_d       = buf_inst_q;
                        inst_write_d = 1'b1;
                        buf_valid_d  = 1'b0;
                        state_d      = S_REQ;
                    end
                end
                default: ;
            endcase
        end

        imem_req_d = (state_d == S_REQ);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            fetch_pc_q   <= RESET_PC;
            req_pc_q     <= RESET_PC;
            pc_q         <= 32'h0;
            inst_q       <= NOP_INST;
            inst_write_q <= 1'b0;
            misaligned_q <= 1'b0;
            buf_valid_q  <= 1'b0;
            buf_pc_q     <= 32'h0;
            buf_inst_q   <= NOP_INST;
            discard_q    <= 1'b0;
            imem_req_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            req_pc_q     <= req_pc_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_write_q <= inst_write_d;
            misaligned_q <= misaligned_d;
            buf_valid_q  <= buf_valid_d;
            buf_pc_q     <= buf_pc_d;
            buf_inst_q   <= buf_inst_d;
            discard_q    <= discard_d;
            imem_req_q   <= imem_req_d;
        end
    end

    assign imemReq    = imem_req_q;
    assign imemAddr   = fetch_pc_q;
    assign PC         = pc_q;
    assign inst       = inst_q;
    assign instWrite  = inst_write_q;
    assign misaligned = misaligned_q;
    assign dbg_state  = state_q;

endmodule
